// File: rtl/output_compare_if.sv
// Bus between software-side control and the output-compare channel:
// counter value, compare/mode load, ACK, and the pin/flag/status outputs.
interface output_compare_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] ivCuenta;
    logic [WIDTH-1:0] ivComparacion;
    logic [1:0]       ivModo;
    logic             iCargar;
    logic             iAck;
    logic             oSalida;
    logic             oComparaFlag;
    logic             oSobreescritura;
    logic             oArmado;

    modport master (
        output ivCuenta, ivComparacion, ivModo, iCargar, iAck,
        input  oSalida, oComparaFlag, oSobreescritura, oArmado
    );

    modport slave (
        input  ivCuenta, ivComparacion, ivModo, iCargar, iAck,
        output oSalida, oComparaFlag, oSobreescritura, oArmado
    );
endinterface

// File: rtl/output_compare.sv
// One-shot output-compare channel: on count == compare it toggles/sets/clears
// or pulses the output pin and raises a sticky flag with overrun detection.
module output_compare #(
    parameter int WIDTH     = 8,
    parameter int PULSE_LEN = 4
) (
    input  logic          iClk,
    input  logic          iReset,
    output_compare_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, PULSE = 2'd2} state_t;

    localparam logic [7:0] PULSE_INIT = 8'(PULSE_LEN - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cmp_q, cmp_nxt;
    logic [1:0]       modo_q, modo_nxt;
    logic [7:0]       cnt_q, cnt_nxt;
    logic             salida_q, salida_nxt;
    logic             flag_q, flag_nxt;
    logic             sobre_q, sobre_nxt;
    logic             armado_q;
    logic             load;
    logic             match;

    // A load in the same cycle as an equal count wins over the match.
    assign load  = bus.iCargar && (state != PULSE);
    assign match = (state == ARMED) && (bus.ivCuenta == cmp_q) && !bus.iCargar;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state    <= IDLE;
            cmp_q    <= '0;
            modo_q   <= 2'b00;
            cnt_q    <= 8'd0;
            salida_q <= 1'b0;
            flag_q   <= 1'b0;
            sobre_q  <= 1'b0;
            armado_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmp_q    <= cmp_nxt;
            modo_q   <= modo_nxt;
            cnt_q    <= cnt_nxt;
            salida_q <= salida_nxt;
            flag_q   <= flag_nxt;
            sobre_q  <= sobre_nxt;
            armado_q <= (state_nxt == ARMED);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) state_nxt = ARMED;
            end
            ARMED: begin
                if (load)
                    state_nxt = ARMED;
                else if (match)
                    state_nxt = (modo_q == 2'b11) ? PULSE : IDLE;
            end
            PULSE: begin
                if (cnt_q == 8'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmp_nxt    = cmp_q;
        modo_nxt   = modo_q;
        cnt_nxt    = cnt_q;
        salida_nxt = salida_q;
        flag_nxt   = flag_q;
        sobre_nxt  = sobre_q;

        if (load) begin
            cmp_nxt  = bus.ivComparacion;
            modo_nxt = bus.ivModo;
        end

        if (match) begin
            case (modo_q)
                2'b00: salida_nxt = ~salida_q;
                2'b01: salida_nxt = 1'b1;
                2'b10: salida_nxt = 1'b0;
                default: begin
                    salida_nxt = 1'b1;
                    cnt_nxt    = PULSE_INIT;
                end
            endcase
        end else if (state == PULSE) begin
            if (cnt_q == 8'd0)
                salida_nxt = 1'b0;
            else
                cnt_nxt = cnt_q - 8'd1;
        end

        // Match beats ACK for the flag; overrun is set only if the flag was already up.
        if (match) begin
            flag_nxt = 1'b1;
            if (flag_q)
                sobre_nxt = 1'b1;
            else if (bus.iAck)
                sobre_nxt = 1'b0;
        end else if (bus.iAck) begin
            flag_nxt  = 1'b0;
            sobre_nxt = 1'b0;
        end
    end

    assign bus.oSalida         = salida_q;
    assign bus.oComparaFlag    = flag_q;
    assign bus.oSobreescritura = sobre_q;
    assign bus.oArmado         = armado_q;
endmodule

// File: tb/tb_output_compare.sv
// Scoreboard bench for output_compare: a cycle model pushes expected outputs
// per driven cycle, popped and compared after the clock edge; plus directed checks.
module tb_output_compare;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    output_compare_if #(.WIDTH(8)) bus ();

    output_compare #(.WIDTH(8), .PULSE_LEN(4)) dut (
        .iClk   (clk),
        .iReset (rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic sal;
        logic flag;
        logic sobre;
        logic armado;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: 0 idle, 1 armed, 2 pulse
    int         m_state = 0;
    logic [7:0] m_cmp   = 8'h00;
    logic [1:0] m_mode  = 2'b00;
    int         m_cnt   = 0;
    logic       m_sal   = 1'b0;
    logic       m_flag  = 1'b0;
    logic       m_sobre = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] c, input logic ld, input logic [7:0] cv,
                        input logic [1:0] md, input logic ak, input logic r);
        exp_t e;
        exp_t got;
        logic hit;
        logic ld_ok;
        bus.ivCuenta      = c;
        bus.iCargar       = ld;
        bus.ivComparacion = cv;
        bus.ivModo        = md;
        bus.iAck          = ak;
        rst               = r;

        if (r) begin
            m_state = 0; m_cmp = 8'h00; m_mode = 2'b00; m_cnt = 0;
            m_sal = 1'b0; m_flag = 1'b0; m_sobre = 1'b0;
        end else begin
            hit   = (m_state == 1) && (c == m_cmp) && !ld;
            ld_ok = ld && (m_state != 2);
            if (hit) begin
                if (m_flag) m_sobre = 1'b1;
                else if (ak) m_sobre = 1'b0;
                m_flag = 1'b1;
            end else if (ak) begin
                m_flag  = 1'b0;
                m_sobre = 1'b0;
            end
            if (ld_ok) begin
                m_cmp = cv; m_mode = md; m_state = 1;
            end else if (hit) begin
                if (m_mode == 2'b00) begin m_sal = ~m_sal; m_state = 0; end
                else if (m_mode == 2'b01) begin m_sal = 1'b1; m_state = 0; end
                else if (m_mode == 2'b10) begin m_sal = 1'b0; m_state = 0; end
                else begin m_sal = 1'b1; m_cnt = 3; m_state = 2; end
            end else if (m_state == 2) begin
                if (m_cnt == 0) begin m_sal = 1'b0; m_state = 0; end
                else m_cnt = m_cnt - 1;
            end
        end
        e.sal    = m_sal;
        e.flag   = m_flag;
        e.sobre  = m_sobre;
        e.armado = (m_state == 1);
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("sb_salida", bus.oSalida, got.sal);
        check("sb_flag", bus.oComparaFlag, got.flag);
        check("sb_sobre", bus.oSobreescritura, got.sobre);
        check("sb_armado", bus.oArmado, got.armado);
    endtask

    task automatic tick(input logic [7:0] c);
        step(c, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] c, input logic [7:0] cv, input logic [1:0] md);
        step(c, 1'b1, cv, md, 1'b0, 1'b0);
    endtask

    task automatic ack(input logic [7:0] c);
        step(c, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ivCuenta = 8'h00; bus.ivComparacion = 8'h00; bus.ivModo = 2'b00;
        bus.iCargar = 1'b0; bus.iAck = 1'b0;

        // Reset held two cycles with an arbitrary count
        step(8'h00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        step(8'h10, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        check("rst_salida", bus.oSalida, 1'b0);
        check("rst_flag", bus.oComparaFlag, 1'b0);
        check("rst_armado", bus.oArmado, 1'b0);
        for (int i = 0; i < 4; i++) tick(8'(i));
        check("idle_no_match", bus.oComparaFlag, 1'b0);

        // Set mode
        load(8'h00, 8'h10, 2'b01);
        check("set_armed", bus.oArmado, 1'b1);
        for (int i = 1; i <= 16; i++) tick(8'(i));
        check("set_salida", bus.oSalida, 1'b1);
        check("set_flag", bus.oComparaFlag, 1'b1);
        check("set_disarm", bus.oArmado, 1'b0);
        ack(8'h11);
        for (int i = 18; i < 256 + 17; i++) tick(8'(i));
        check("set_no_rematch", bus.oComparaFlag, 1'b0);
        check("set_hold", bus.oSalida, 1'b1);

        // Pulse mode, with a load during the pulse that must be ignored
        step(8'h00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        load(8'h00, 8'h05, 2'b11);
        for (int i = 1; i <= 5; i++) tick(8'(i));
        check("pulse_start", bus.oSalida, 1'b1);
        load(8'h06, 8'h07, 2'b01);
        tick(8'h07);
        tick(8'h08);
        check("pulse_high4", bus.oSalida, 1'b1);
        tick(8'h09);
        check("pulse_end", bus.oSalida, 1'b0);
        check("pulse_ld_ignored", bus.oArmado, 1'b0);
        ack(8'h0A);

        // Toggle plus overrun
        load(8'h1E, 8'h20, 2'b00);
        tick(8'h1F);
        tick(8'h20);
        check("tog_first", bus.oSalida, 1'b1);
        load(8'h21, 8'h22, 2'b00);
        tick(8'h22);
        check("tog_second", bus.oSalida, 1'b0);
        check("ovr_set", bus.oSobreescritura, 1'b1);
        ack(8'h23);
        check("ack_flag", bus.oComparaFlag, 1'b0);
        check("ack_sobre", bus.oSobreescritura, 1'b0);

        // ACK on the match cycle, then ACK on a match with flag already set
        load(8'h2E, 8'h30, 2'b01);
        tick(8'h2F);
        step(8'h30, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
        check("ackmatch_flag", bus.oComparaFlag, 1'b1);
        check("ackmatch_sobre", bus.oSobreescritura, 1'b0);
        load(8'h31, 8'h32, 2'b10);
        step(8'h32, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
        check("ackovr_sobre", bus.oSobreescritura, 1'b1);
        check("clear_salida", bus.oSalida, 1'b0);
        ack(8'h33);

        // Load on the matching cycle wins
        load(8'h3E, 8'h40, 2'b01);
        tick(8'h3F);
        load(8'h40, 8'h42, 2'b00);
        check("ldwin_flag", bus.oComparaFlag, 1'b0);
        check("ldwin_armed", bus.oArmado, 1'b1);
        tick(8'h41);
        tick(8'h42);
        check("ldwin_newval", bus.oSalida, 1'b1);
        ack(8'h43);

        // Wrap-around: compare 0 loaded at 0xFE
        load(8'hFE, 8'h00, 2'b10);
        tick(8'hFF);
        check("wrap_wait", bus.oComparaFlag, 1'b0);
        tick(8'h00);
        check("wrap_match", bus.oComparaFlag, 1'b1);
        check("wrap_salida", bus.oSalida, 1'b0);
        ack(8'h01);

        // Loading the current count waits a full period
        load(8'h05, 8'h05, 2'b01);
        for (int i = 6; i < 256 + 5; i++) tick(8'(i));
        check("period_wait", bus.oSalida, 1'b0);
        tick(8'h05);
        check("period_match", bus.oSalida, 1'b1);
        ack(8'h06);

        // Reset mid-pulse truncates it
        load(8'h4F, 8'h50, 2'b11);
        tick(8'h50);
        tick(8'h51);
        check("rstp_high", bus.oSalida, 1'b1);
        step(8'h52, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        check("rstp_low", bus.oSalida, 1'b0);
        check("rstp_flag", bus.oComparaFlag, 1'b0);
        tick(8'h53);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
